// File: rtl/alu32_result_stage.sv
// Registered output stage behind the ALU result mux: captures result plus N/Z/C/V flags
// and presents them over valid/ready through a two-entry skid buffer with a registered in_ready.
module alu32_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       sel,
  input  logic             carry_in,
  input  logic             ovf_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [1:0]       count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Carry and overflow are meaningful only for the arithmetic selects (sel[2:1] == 2'b11).
  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] d, input logic [1:0] s_hi,
                                            input logic c, input logic v);
    logic arith;
    arith = (s_hi == 2'b11);
    calc_flags = {d[WIDTH-1], (d == {WIDTH{1'b0}}), arith & c, arith & v};
  endfunction

  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [3:0]       main_flags_q, main_flags_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [3:0]       skid_flags_q, skid_flags_d;
  logic             accept_s, pop_s;
  logic [3:0]       new_flags_s;

  assign accept_s    = in_valid & in_ready_q;
  assign pop_s       = out_valid_q & out_ready;
  assign new_flags_s = calc_flags(y, sel[2:1], carry_in, ovf_in);

  // Occupancy state machine and storage next-state selection.
  always_comb begin
    count_d      = count_q;
    main_data_d  = main_data_q;
    main_flags_d = main_flags_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    case (count_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_data_d  = y;
          main_flags_d = new_flags_s;
          count_d      = ST_ONE;
        end else begin
          count_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && !pop_s) begin
          skid_data_d  = y;
          skid_flags_d = new_flags_s;
          count_d      = ST_FULL;
        end else if (accept_s && pop_s) begin
          main_data_d  = y;
          main_flags_d = new_flags_s;
          count_d      = ST_ONE;
        end else if (pop_s) begin
          count_d = ST_EMPTY;
        end else begin
          count_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          main_data_d  = skid_data_q;
          main_flags_d = skid_flags_q;
          count_d      = ST_ONE;
        end else begin
          count_d = ST_FULL;
        end
      end
      default: begin
        count_d = ST_EMPTY;
      end
    endcase
    in_ready_d  = (count_d != ST_FULL);
    out_valid_d = (count_d != ST_EMPTY);
  end

  // State and storage registers; reset drops both entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      main_data_q  <= {WIDTH{1'b0}};
      main_flags_q <= 4'b0000;
      skid_data_q  <= {WIDTH{1'b0}};
      skid_flags_q <= 4'b0000;
    end else begin
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      main_data_q  <= main_data_d;
      main_flags_q <= main_flags_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = main_data_q;
  assign flags     = main_flags_q;
  assign count     = count_q;

endmodule

// File: tb/tb_alu32_result_stage.sv
// Bench for alu32_result_stage: directed scenarios plus randomized traffic checked
// against a queue-based FIFO model of the stage.
module tb_alu32_result_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic [2:0]   sel;
  logic         carry_in;
  logic         ovf_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [1:0]   count;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   flg;
  } entry_t;

  entry_t q[$];
  int checks = 0;
  int errors = 0;

  alu32_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .sel(sel), .carry_in(carry_in), .ovf_in(ovf_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(input logic [W-1:0] d, input logic [2:0] s,
                                             input logic c, input logic v);
    logic n, z, cc, vv;
    n  = (d >= 32'h8000_0000);
    z  = (d == 32'd0);
    cc = (s == 3'd6 || s == 3'd7) ? c : 1'b0;
    vv = (s == 3'd6 || s == 3'd7) ? v : 1'b0;
    return {n, z, cc, vv};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit     acc, pp;
    entry_t e;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() != 2);
      pp  = (q.size() != 0) && out_ready;
      if (pp) e = q.pop_front();
      if (acc) q.push_back('{data: y, flg: model_flags(y, sel, carry_in, ovf_in)});
    end
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() != 2);
    if (q.size() != 0) begin
      chk("result", result, q[0].data);
      chk("flags", flags, q[0].flg);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [2:0] s,
                       input logic c, input logic o);
    in_valid = v; y = d; sel = s; carry_in = c; ovf_in = o;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_result", result, 32'd0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);

    // Streaming with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0000, 3'b000, 1'b0, 1'b0); step();
    chk("stream0_flags", flags, 4'b0100);
    drive(1'b1, 32'h8000_0000, 3'b000, 1'b0, 1'b0); step();
    chk("stream1_flags", flags, 4'b1000);
    drive(1'b1, 32'h0000_0001, 3'b000, 1'b0, 1'b0); step();
    chk("stream2_flags", flags, 4'b0000);
    chk("stream_count", count, 2'd1);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0); step();

    // Arithmetic flag gating
    drive(1'b1, 32'h0000_0000, 3'b110, 1'b1, 1'b1); step();
    chk("arith_flags", flags, 4'b0111);
    drive(1'b1, 32'h0000_0000, 3'b011, 1'b1, 1'b1); step();
    chk("logic_flags", flags, 4'b0100);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0); step();

    // Backpressure: A, B accepted, C held upstream
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 3'b001, 1'b0, 1'b0); step();
    drive(1'b1, 32'hBBBB_0002, 3'b111, 1'b1, 1'b0); step();
    drive(1'b1, 32'hCCCC_0003, 3'b110, 1'b0, 1'b1); step();
    chk("bp_count", count, 2'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    step();
    chk("bp_hold", result, 32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    chk("bp_second", result, 32'hBBBB_0002);
    step();
    chk("bp_third", result, 32'hCCCC_0003);

    // Simultaneous accept and pop in ONE
    drive(1'b1, 32'hDDDD_0004, 3'b010, 1'b0, 1'b0); step();
    chk("one_both_count", count, 2'd1);
    chk("one_both_result", result, 32'hDDDD_0004);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0); step();

    // Reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 3'b111, 1'b1, 1'b1); step();
    drive(1'b1, 32'h8765_4321, 3'b111, 1'b1, 1'b1); step();
    chk("full_count", count, 2'd2);
    reset = 1'b1; out_ready = 1'b1; step();
    chk("rstfull_valid", out_valid, 1'b0);
    chk("rstfull_flags", flags, 4'b0000);
    chk("rstfull_result", result, 32'd0);
    reset = 1'b0; drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0); step();
    chk("rstfull_in_ready", in_ready, 1'b1);
    step();

    // Random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 3))
        0: d = 32'd0;
        1: d = 32'h8000_0000 | $urandom;
        default: d = $urandom;
      endcase
      drive(1'($urandom_range(0, 1)), d, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
